fetch_sequencer: RTL and testbench

- Fetch controller for the pico-MIPS core. Owns the program counter and drives the address of the combinational program memory.
- Registers the returned instruction into an instruction register with a valid flag, and redirects on branch/jump with a one-bubble squash.
- Supports stall, halt and resume.
- Sits between program memory and the decode/execute stage.

---
 rtl/fetch_sequencer.sv | 110 +++++++++++
 tb/tb_fetch_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetch controller for the pico-MIPS core.
// Owns the pc, drives the combinational program memory address and registers
// the returned word into instr_out/ir_pc/instr_valid. Redirects (jump/branch)
// squash the wrong-path fetch with a one-cycle bubble; supports stall/halt/resume.
// Ports: clk, n_reset (async active-low); address -> memory, instr_in <- memory;
//        stall, branch_en/branch_offset, jump_en/jump_target, halt_req, resume in;
//        instr_out, ir_pc, instr_valid, halted out.
module fetch_sequencer #(
  parameter  int N             = 8,
  parameter  int AddrSz        = 6,
  localparam int InstructionSz = N + 16
) (
  input  logic                     clk,
  input  logic                     n_reset,
  output logic [AddrSz-1:0]        address,
  input  logic [InstructionSz-1:0] instr_in,
  input  logic                     stall,
  input  logic                     branch_en,
  input  logic [AddrSz-1:0]        branch_offset,
  input  logic                     jump_en,
  input  logic [AddrSz-1:0]        jump_target,
  input  logic                     halt_req,
  input  logic                     resume,
  output logic [InstructionSz-1:0] instr_out,
  output logic [AddrSz-1:0]        ir_pc,
  output logic                     instr_valid,
  output logic                     halted
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  localparam logic [AddrSz-1:0] AddrOne = {{(AddrSz-1){1'b0}}, 1'b1};

  state_t                   state, state_nx;
  logic [AddrSz-1:0]        pc, pc_nx;
  logic [InstructionSz-1:0] instr_nx;
  logic [AddrSz-1:0]        ir_pc_nx;
  logic                     valid_nx;
  logic                     redirect;
  logic [AddrSz-1:0]        target;

  assign address = pc;
  assign halted  = (state == HALT);

  // Redirects only act on a valid instruction; bubbles, BOOT and HALT all
  // have instr_valid=0, so stale branch/jump requests are ignored there.
  assign redirect = instr_valid && (jump_en || branch_en);
  // Offset is already AddrSz wide, so sign extension is the identity and the
  // sum wraps modulo the memory depth.
  assign target   = jump_en ? jump_target : (ir_pc + AddrOne + branch_offset);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state       <= BOOT;
      pc          <= '0;
      instr_out   <= '0;
      ir_pc       <= '0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      instr_out   <= instr_nx;
      ir_pc       <= ir_pc_nx;
      instr_valid <= valid_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    instr_nx = instr_out;
    ir_pc_nx = ir_pc;
    valid_nx = instr_valid;

    unique case (state)
      BOOT: begin
        state_nx = halt_req ? HALT : RUN;
      end

      RUN: begin
        if (!stall) begin
          if (redirect) begin
            pc_nx    = target;
            valid_nx = 1'b0;
          end else if (!halt_req) begin
            instr_nx = instr_in;
            ir_pc_nx = pc;
            valid_nx = 1'b1;
            pc_nx    = pc + AddrOne;
          end else begin
            // Halting without redirect: pc kept so that word is fetched on resume.
            valid_nx = 1'b0;
          end
          if (halt_req) state_nx = HALT;
        end
      end

      HALT: begin
        valid_nx = 1'b0;
        // Resume edge does not fetch; the held pc is fetched on the next RUN edge.
        if (resume && !halt_req) state_nx = RUN;
      end

      default: begin
        state_nx = BOOT;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        n_reset;
  logic [5:0]  address;
  logic [23:0] instr_in;
  logic        stall, branch_en, jump_en, halt_req, resume;
  logic [5:0]  branch_offset, jump_target;
  logic [23:0] instr_out;
  logic [5:0]  ir_pc;
  logic        instr_valid, halted;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Program memory model: rom[i] = i.
  assign instr_in = {18'd0, address};

  fetch_sequencer dut (
    .clk           (clk),
    .n_reset       (n_reset),
    .address       (address),
    .instr_in      (instr_in),
    .stall         (stall),
    .branch_en     (branch_en),
    .branch_offset (branch_offset),
    .jump_en       (jump_en),
    .jump_target   (jump_target),
    .halt_req      (halt_req),
    .resume        (resume),
    .instr_out     (instr_out),
    .ir_pc         (ir_pc),
    .instr_valid   (instr_valid),
    .halted        (halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check a normal fetch result: instr_out = rom[a] = a, pc = a+1.
  task automatic chk_fetch(input string tag, input logic [5:0] a);
    logic [5:0] nxt;
    nxt = a + 6'd1;
    chk({tag, ".ir_pc"}, 32'(ir_pc), 32'(a));
    chk({tag, ".instr_out"}, 32'(instr_out), 32'(a));
    chk({tag, ".valid"}, 32'(instr_valid), 32'd1);
    chk({tag, ".pc"}, 32'(address), 32'(nxt));
  endtask

  initial begin
    n_reset = 1'b0; stall = 0; branch_en = 0; jump_en = 0; halt_req = 0; resume = 0;
    branch_offset = '0; jump_target = '0;
    #2;
    chk("rst.pc", 32'(address), 0);
    chk("rst.instr_out", 32'(instr_out), 0);
    chk("rst.ir_pc", 32'(ir_pc), 0);
    chk("rst.valid", 32'(instr_valid), 0);
    chk("rst.halted", 32'(halted), 0);
    step(); step();
    n_reset = 1'b1;

    // BOOT edge: nothing fetched yet.
    step();
    chk("boot.valid", 32'(instr_valid), 0);
    chk("boot.pc", 32'(address), 0);
    chk("boot.halted", 32'(halted), 0);

    // 66 sequential fetches, wrapping 63 -> 0.
    for (int k = 0; k < 66; k++) begin
      step();
      chk_fetch("seq", 6'(k));
    end
    for (int k = 2; k <= 5; k++) begin
      step();
      chk_fetch("seq2", 6'(k));
    end

    // Branch at ir_pc=5, offset -3 -> target 3.
    branch_en = 1; branch_offset = 6'h3D;
    step();
    chk("br.valid", 32'(instr_valid), 0);
    chk("br.pc", 32'(address), 3);
    chk("br.ir_pc_held", 32'(ir_pc), 5);
    branch_en = 0;
    step();
    chk_fetch("br.tgt", 6'd3);

    for (int k = 4; k <= 10; k++) begin
      step();
      chk_fetch("seq3", 6'(k));
    end

    // Jump beats branch at ir_pc=10.
    jump_en = 1; jump_target = 6'd40; branch_en = 1; branch_offset = 6'd2;
    step();
    chk("prio.pc", 32'(address), 40);
    chk("prio.valid", 32'(instr_valid), 0);
    jump_en = 0; branch_en = 0;
    step();
    chk_fetch("prio.tgt", 6'd40);

    // Stall holds everything and blocks a jump.
    stall = 1; jump_en = 1; jump_target = 6'd7;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_fetch("stall", 6'd40);
    end
    stall = 0; jump_en = 0;
    step();
    chk_fetch("unstall", 6'd41);

    // Jump to 8, then halt in the bubble with pc=8.
    jump_en = 1; jump_target = 6'd8;
    step();
    chk("j8.pc", 32'(address), 8);
    jump_en = 0; halt_req = 1;
    step();
    chk("halt.halted", 32'(halted), 1);
    chk("halt.valid", 32'(instr_valid), 0);
    chk("halt.pc", 32'(address), 8);
    resume = 1;
    step();
    chk("halt_res.halted", 32'(halted), 1);
    chk("halt_res.pc", 32'(address), 8);
    halt_req = 0;
    step();
    chk("resume.halted", 32'(halted), 0);
    chk("resume.valid", 32'(instr_valid), 0);
    chk("resume.pc", 32'(address), 8);
    resume = 0;
    step();
    chk_fetch("resume.fetch", 6'd8);

    // Halt together with a jump: jump applied to pc, then halt.
    jump_en = 1; jump_target = 6'd30; halt_req = 1;
    step();
    chk("hj.halted", 32'(halted), 1);
    chk("hj.pc", 32'(address), 30);
    chk("hj.valid", 32'(instr_valid), 0);
    jump_en = 0; halt_req = 0; resume = 1;
    step();
    chk("hj.resume", 32'(halted), 0);
    resume = 0;
    step();
    chk_fetch("hj.fetch", 6'd30);

    // Reach ir_pc=20, then asynchronous reset between edges.
    jump_en = 1; jump_target = 6'd20;
    step();
    jump_en = 0;
    step();
    chk_fetch("pre_rst", 6'd20);
    #2;
    n_reset = 1'b0;
    #1;
    chk("arst.pc", 32'(address), 0);
    chk("arst.valid", 32'(instr_valid), 0);
    chk("arst.halted", 32'(halted), 0);
    chk("arst.ir_pc", 32'(ir_pc), 0);
    chk("arst.instr_out", 32'(instr_out), 0);
    n_reset = 1'b1;
    step();
    chk("arst.boot_valid", 32'(instr_valid), 0);
    chk("arst.boot_pc", 32'(address), 0);
    step();
    chk_fetch("arst.fetch0", 6'd0);

    // halt_req during BOOT goes straight to HALT.
    #2;
    n_reset = 1'b0;
    halt_req = 1;
    #1;
    n_reset = 1'b1;
    step();
    chk("boot_halt.halted", 32'(halted), 1);
    chk("boot_halt.pc", 32'(address), 0);
    halt_req = 0;
    step();
    chk("boot_halt.stay", 32'(halted), 1);
    chk("boot_halt.valid", 32'(instr_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
